load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns single core load/store requests into a
// request/grant/read-valid bus transaction. It checks alignment and funct3
// legality, formats store byte lanes, extends load data and aborts stalled
// bus transactions with an error after TIMEOUT cycles.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    // core side
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    // bus side
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Last counter value before the transaction is abandoned.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    state_t      state;
    logic [9:0]  cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        we_q;

    logic        legal;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // The core is frozen until the completion pulse arrives.
    assign stall = req_valid & ~rsp_valid;

    // Legality check and store lane formatting for the incoming request.
    always_comb begin
        legal   = 1'b0;
        be_n    = 4'b0000;
        wdata_n = 32'h0;
        case (req_funct3)
            3'b000: begin
                legal   = 1'b1;
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                legal   = ~req_addr[0];
                be_n    = 4'b0011 << req_addr[1:0];
                wdata_n = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                legal   = (req_addr[1:0] == 2'b00);
                be_n    = 4'b1111;
                wdata_n = req_wdata;
            end
            // Unsigned loads only; the halfword form still needs alignment.
            3'b100, 3'b101: legal = ~req_we & ~(req_funct3[0] & req_addr[0]);
            default: legal = 1'b0;
        endcase
        if (!req_we) begin
            be_n    = 4'b0000;
            wdata_n = 32'h0;
        end
    end

    // Align the addressed byte/half to bit 0 and sign/zero extend it.
    always_comb begin
        shifted   = mem_rdata >> {off_q, 3'b000};
        load_data = shifted;
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= 10'd0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            we_q      <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= be_n;
                        mem_wdata <= wdata_n;
                        req_ready <= 1'b0;
                        if (legal) begin
                            state   <= StReq;
                            cnt     <= 10'd0;
                            mem_req <= 1'b1;
                            mem_we  <= req_we;
                        end else begin
                            // Rejected requests never touch the bus.
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end
                    end
                end
                StReq: begin
                    // A grant in the final counted cycle still wins over the abort.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (we_q) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state <= StWait;
                            cnt   <= cnt + 10'd1;
                        end
                    end else if (cnt == TO_LAST) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                    end else if (cnt == TO_LAST) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
